dff_monitor: RTL and testbench

Synthesizable self-checking monitor for a single-bit flip-flop under test. Each clock it samples the data driven into the DUT (`d_obs`) and the DUT output (`q_obs`). It checks that `q_obs` equals `d_obs` delayed by a fixed number of cycles, and keeps match, mismatch and first-failure records. It sits next to a `dff`-style DUT in hardware bring-up builds and is the receiving/checking end of the stimulus path that toggles `d`.

---
 rtl/dff_mon_pkg.sv | 17 +
 rtl/bit_delay_line.sv | 44 ++++
 rtl/dff_monitor.sv | 122 ++++++++++++
 tb/tb_dff_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_mon_pkg.sv
// Shared types and limits for the single-bit flip-flop monitor.
package dff_mon_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    HALT   = 2'd2
  } mon_state_t;

  localparam int LATENCY_MAX = 8;

  // Value the warm-up edge counter holds on the edge where the history tail becomes valid.
  function automatic logic [3:0] warm_last(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Delays a single bit by DEPTH edges and tracks which stages hold captured data.
module bit_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic valid
);

  logic [DEPTH-1:0] hist_reg;
  logic [DEPTH-1:0] vld_reg;
  logic [DEPTH-1:0] hist_next;
  logic [DEPTH-1:0] vld_next;

  generate
    if (DEPTH == 1) begin : g_single
      assign hist_next = din;
      assign vld_next  = 1'b1;
    end else begin : g_chain
      assign hist_next = {hist_reg[DEPTH-2:0], din};
      assign vld_next  = {vld_reg[DEPTH-2:0], 1'b1};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg <= '0;
      vld_reg  <= '0;
    end else if (clr) begin
      hist_reg <= '0;
      vld_reg  <= '0;
    end else begin
      hist_reg <= hist_next;
      vld_reg  <= vld_next;
    end
  end

  assign dout  = hist_reg[DEPTH-1];
  assign valid = vld_reg[DEPTH-1];

endmodule

// File: rtl/dff_monitor.sv
// Checks that q_obs equals d_obs delayed by LATENCY edges; keeps sample, error and first-failure records.
module dff_monitor
  import dff_mon_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             d_obs,
  input  logic             q_obs,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             error,
  output logic             halted,
  output logic             ready
);

  generate
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("dff_monitor: LATENCY must be within 1..LATENCY_MAX");
    end
  endgenerate

  logic       expected;
  logic       hist_valid;
  logic       compare;
  logic       mismatch;
  mon_state_t state_reg;
  mon_state_t state_next;
  logic [3:0] warm_cnt_reg;
  logic [3:0] warm_cnt_next;

  logic [CNT_W-1:0] sample_count_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic [CNT_W-1:0] first_err_idx_reg;
  logic             error_reg;

  bit_delay_line #(
    .DEPTH(LATENCY)
  ) u_hist (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .din  (d_obs),
    .dout (expected),
    .valid(hist_valid)
  );

  assign compare = (state_reg == CHECK) && en && hist_valid;

  // Written as if/else so an X or Z on q_obs falls into the mismatch branch in simulation.
  always_comb begin
    mismatch = 1'b0;
    if (compare) begin
      if (q_obs == expected) mismatch = 1'b0;
      else                   mismatch = 1'b1;
    end
  end

  // The warm-up counter lets CHECK begin on the same edge the history tail becomes valid.
  always_comb begin
    state_next    = state_reg;
    warm_cnt_next = warm_cnt_reg;
    case (state_reg)
      WARMUP: begin
        if (warm_cnt_reg == warm_last(LATENCY)) state_next = CHECK;
        else                                    warm_cnt_next = warm_cnt_reg + 4'd1;
      end
      CHECK:   if (STOP_ON_ERR && mismatch) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = WARMUP;
    endcase
    if (clr) begin
      state_next    = WARMUP;
      warm_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= WARMUP;
      warm_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      warm_cnt_reg <= warm_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_count_reg  <= '0;
      err_count_reg     <= '0;
      first_err_idx_reg <= '0;
      error_reg         <= 1'b0;
    end else if (clr) begin
      sample_count_reg  <= '0;
      err_count_reg     <= '0;
      first_err_idx_reg <= '0;
      error_reg         <= 1'b0;
    end else if (compare) begin
      if (sample_count_reg != '1) sample_count_reg <= sample_count_reg + 1'b1;
      if (mismatch) begin
        if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
        if (!error_reg) first_err_idx_reg <= sample_count_reg;
        error_reg <= 1'b1;
      end
    end
  end

  assign sample_count  = sample_count_reg;
  assign err_count     = err_count_reg;
  assign first_err_idx = first_err_idx_reg;
  assign error         = error_reg;
  assign halted        = (state_reg == HALT);
  assign ready         = (state_reg != WARMUP);

endmodule

// File: tb/tb_dff_monitor.sv
// Four monitor instances (latency 1, latency 1 stop-on-error, latency 3, latency 2 on a 3-deep DUT) checked against a behavioural model.
module tb_dff_monitor;

  localparam int N = 4;
  localparam int LAT_T [N] = '{1, 1, 3, 2};
  localparam bit STOP_T[N] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b0;
  logic d = 1'b0;
  logic fault1 = 1'b0;
  logic stuck = 1'b0;
  logic q1, q3a, q3b, q3;
  logic q_in[N];

  logic [15:0] sc_o[N];
  logic [15:0] ec_o[N];
  logic [15:0] fi_o[N];
  logic        er_o[N];
  logic        hl_o[N];
  logic        rd_o[N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Bench-side DUTs: one flop and a chain of three flops.
  always @(posedge clk) begin
    q1  <= d;
    q3a <= d;
    q3b <= q3a;
    q3  <= q3b;
  end

  assign q_in[0] = q1 ^ fault1;
  assign q_in[1] = stuck ? 1'b0 : q1;
  assign q_in[2] = q3;
  assign q_in[3] = q3;

  dff_monitor #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_l1 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d), .q_obs(q_in[0]),
    .sample_count(sc_o[0]), .err_count(ec_o[0]), .first_err_idx(fi_o[0]),
    .error(er_o[0]), .halted(hl_o[0]), .ready(rd_o[0]));

  dff_monitor #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d), .q_obs(q_in[1]),
    .sample_count(sc_o[1]), .err_count(ec_o[1]), .first_err_idx(fi_o[1]),
    .error(er_o[1]), .halted(hl_o[1]), .ready(rd_o[1]));

  dff_monitor #(.LATENCY(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_l3 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d), .q_obs(q_in[2]),
    .sample_count(sc_o[2]), .err_count(ec_o[2]), .first_err_idx(fi_o[2]),
    .error(er_o[2]), .halted(hl_o[2]), .ready(rd_o[2]));

  dff_monitor #(.LATENCY(2), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_l2 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d_obs(d), .q_obs(q_in[3]),
    .sample_count(sc_o[3]), .err_count(ec_o[3]), .first_err_idx(fi_o[3]),
    .error(er_o[3]), .halted(hl_o[3]), .ready(rd_o[3]));

  // Model: counts edges since start, keeps the last 8 d values, compares once edge count exceeds latency.
  typedef struct {
    int         edges;
    logic [7:0] dh;
    int         sc;
    int         ec;
    int         fi;
    bit         err;
    bit         halt;
  } mdl_t;

  mdl_t m[N];

  function automatic mdl_t mzero();
    mdl_t r;
    r.edges = 0; r.dh = '0; r.sc = 0; r.ec = 0; r.fi = 0; r.err = 1'b0; r.halt = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int lat, bit stop, logic q_now, logic d_now, logic en_now);
    mdl_t r = s;
    if (r.edges < 1000) r.edges++;
    if (!r.halt && en_now && r.edges >= lat + 1) begin
      if (q_now !== r.dh[lat-1]) begin
        r.ec++;
        if (!r.err) r.fi = r.sc;
        r.err = 1'b1;
        if (stop) r.halt = 1'b1;
      end
      r.sc++;
    end
    r.dh = {r.dh[6:0], d_now};
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset || clr) m[i] = mzero();
      else               m[i] = mstep(m[i], LAT_T[i], STOP_T[i], q_in[i], d, en);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      mdl_t e;
      e = reset ? m[i] : mzero();
      chk($sformatf("u%0d.sample_count", i), 32'(sc_o[i]), 32'(e.sc));
      chk($sformatf("u%0d.err_count", i), 32'(ec_o[i]), 32'(e.ec));
      chk($sformatf("u%0d.first_err_idx", i), 32'(fi_o[i]), 32'(e.fi));
      chk($sformatf("u%0d.error", i), 32'(er_o[i]), 32'(e.err));
      chk($sformatf("u%0d.halted", i), 32'(hl_o[i]), 32'(e.halt));
      chk($sformatf("u%0d.ready", i), 32'(rd_o[i]), 32'(e.edges >= LAT_T[i]));
    end
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.sample_count", 32'(sc_o[0]), 0);
    chk("reset.ready", 32'(rd_o[0]), 0);
    reset = 1'b1;
    en = 1'b1;

    // Ideal flop, d toggling every cycle, 20 edges.
    repeat (20) begin
      d = ~d;
      @(negedge clk);
    end
    $display("pass run: u_l1 sample_count=%0d err_count=%0d", sc_o[0], ec_o[0]);
    chk("pass.sample_count", 32'(sc_o[0]), 19);
    chk("pass.err_count", 32'(ec_o[0]), 0);
    chk("pass.error", 32'(er_o[0]), 0);
    chk("pass.ready", 32'(rd_o[0]), 1);
    chk("pass.l3_sample_count", 32'(sc_o[2]), 17);
    chk("pass.l2_has_errors", 32'(ec_o[3] != 0), 1);

    // One-cycle inverted q at comparison index 7.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) begin
      d = ~d;
      fault1 = (m[0].sc == 7);
      @(negedge clk);
    end
    fault1 = 1'b0;
    $display("fault run: err_count=%0d first_err_idx=%0d", ec_o[0], fi_o[0]);
    chk("fault.err_count", 32'(ec_o[0]), 1);
    chk("fault.first_err_idx", 32'(fi_o[0]), 7);
    chk("fault.error", 32'(er_o[0]), 1);
    chk("fault.sample_count", 32'(sc_o[0]), 19);

    // Stuck-at-0 output with stop-on-error.
    clr = 1'b1;
    d = 1'b1;
    stuck = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    $display("stop run: halted=%0d sample_count=%0d", hl_o[1], sc_o[1]);
    chk("stop.halted", 32'(hl_o[1]), 1);
    chk("stop.sample_count", 32'(sc_o[1]), 1);
    chk("stop.err_count", 32'(ec_o[1]), 1);
    chk("stop.first_err_idx", 32'(fi_o[1]), 0);
    clr = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    chk("stop_clr.halted", 32'(hl_o[1]), 0);
    chk("stop_clr.error", 32'(er_o[1]), 0);
    chk("stop_clr.ready", 32'(rd_o[1]), 0);
    chk("stop_clr.sample_count", 32'(sc_o[1]), 0);

    // Random d for 100 edges, en low for 5 of them.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      d  = 1'($urandom);
      en = !(k >= 40 && k < 45);
      @(negedge clk);
      if (k == 2) chk("l3.no_compare_edge3", 32'(sc_o[2]), 0);
      if (k == 3) chk("l3.first_compare_edge4", 32'(sc_o[2]), 1);
    end
    en = 1'b1;
    $display("random run: l3 sample_count=%0d err_count=%0d, l2 err_count=%0d", sc_o[2], ec_o[2], ec_o[3]);
    chk("rand.l3_sample_count", 32'(sc_o[2]), 92);
    chk("rand.l3_err_count", 32'(ec_o[2]), 0);
    chk("rand.l1_sample_count", 32'(sc_o[0]), 94);
    chk("rand.l2_has_errors", 32'(ec_o[3] != 0), 1);

    // clr on the same edge as a mismatch.
    d = ~d;
    fault1 = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    fault1 = 1'b0;
    chk("clr_mis.sample_count", 32'(sc_o[0]), 0);
    chk("clr_mis.err_count", 32'(ec_o[0]), 0);
    chk("clr_mis.error", 32'(er_o[0]), 0);
    chk("clr_mis.ready", 32'(rd_o[0]), 0);

    // Asynchronous reset between edges.
    repeat (10) begin
      d = 1'($urandom);
      @(negedge clk);
    end
    chk("async.pre_sample_count", 32'(sc_o[0]), 9);
    #2 reset = 1'b0;
    #1;
    $display("async reset: sample_count=%0d ready=%0d", sc_o[0], rd_o[0]);
    chk("async.sample_count", 32'(sc_o[0]), 0);
    chk("async.l3_sample_count", 32'(sc_o[2]), 0);
    chk("async.ready", 32'(rd_o[0]), 0);
    chk("async.l2_err_count", 32'(ec_o[3]), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      d = 1'($urandom);
      @(negedge clk);
    end
    chk("rewarm.l1_sample_count", 32'(sc_o[0]), 4);
    chk("rewarm.l3_sample_count", 32'(sc_o[2]), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
